// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin arbiter sharing one data RAM between the CPU (m0) and a loader (m1).
// Each grant runs IDLE -> ACCESS -> DONE, and the ack pulses in DONE with the registered read data.
module ram_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [2:0]        m0_access,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [2:0]        m1_access,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              slv_load,
    output logic              slv_store,
    output logic [2:0]        slv_access,
    output logic [ADDR_W-1:0] slv_addr,
    output logic [DATA_W-1:0] slv_wdata,
    input  logic [DATA_W-1:0] slv_rdata,
    output logic              cpu_stall
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    state_t state, next;
    logic last_grant, sel, win, cmd_we;
    logic [2:0] cmd_access;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata, rdata_q;
    // m1 wins when it is alone, or on a tie when m0 had the last grant
    assign win = m1_req & (~m0_req | ~last_grant);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            sel        <= 1'b0;
            cmd_we     <= 1'b0;
            cmd_access <= '0;
            cmd_addr   <= '0;
            cmd_wdata  <= '0;
            rdata_q    <= '0;
        end else begin
            state <= next;
            if (state == IDLE && (m0_req | m1_req)) begin
                sel        <= win;
                cmd_we     <= win ? m1_we : m0_we;
                cmd_access <= win ? m1_access : m0_access;
                cmd_addr   <= win ? m1_addr : m0_addr;
                cmd_wdata  <= win ? m1_wdata : m0_wdata;
            end
            if (state == ACCESS) begin
                rdata_q    <= slv_rdata;
                last_grant <= sel;
            end
        end
    end
    always_comb begin
        next      = IDLE;
        slv_load  = 1'b0;
        slv_store = 1'b0;
        m0_ack    = 1'b0;
        m1_ack    = 1'b0;
        if (state == IDLE) next = (m0_req | m1_req) ? ACCESS : IDLE;
        if (state == ACCESS) begin
            next      = DONE;
            slv_load  = ~cmd_we;
            slv_store = cmd_we;
        end
        if (state == DONE) begin
            m0_ack = ~sel;
            m1_ack = sel;
        end
    end
    assign slv_access = cmd_access;
    assign slv_addr   = cmd_addr;
    assign slv_wdata  = cmd_wdata;
    assign m0_rdata   = m0_ack ? rdata_q : '0;
    assign m1_rdata   = m1_ack ? rdata_q : '0;
    assign cpu_stall  = m0_req & ~m0_ack;
endmodule
